// File: rtl/ps2_multi_host_rx.sv
// ps2_multi_host_rx: NUM_CH-port PS/2 receiver that merges tagged bytes into one FIFO read through a chip select
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   VPWR, VGND          power rails, pass-through only
//   ps2_clk, ps2_data   per-channel PS/2 lines, asynchronous, idle high
//   cs                  asynchronous chip select; one pop per stable high period
//   int_clear           level; clears interrupt and overflow
//   rd_data/rd_ch/rd_err  last popped entry {channel, error, byte}
//   empty, full         registered FIFO status
//   overflow            sticky, a completed frame was dropped on a full FIFO
//   interrupt           level, at least one push since the last int_clear
module ps2_multi_host_rx #(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int GLITCH     = 4,
    parameter int TIMEOUT    = 2047,
    parameter int CS_STABLE  = 2,
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire               VPWR,
    inout  wire               VGND,
    input  logic [NUM_CH-1:0] ps2_clk,
    input  logic [NUM_CH-1:0] ps2_data,
    input  logic              cs,
    input  logic              int_clear,
    output logic [7:0]        rd_data,
    output logic [CHW-1:0]    rd_ch,
    output logic              rd_err,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              interrupt
);
    localparam int L  = 2 * NUM_CH;
    localparam int GW = $clog2(GLITCH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(CS_STABLE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = CHW + 9;

    wire unused_rails = VPWR ^ VGND;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

    // Line conditioning: bits [NUM_CH-1:0] are clocks, upper bits are data.
    logic [L-1:0]      s1_q, s2_q, filt_q;
    logic [GW-1:0]     gcnt_q [L];
    logic [NUM_CH-1:0] fclk_prev_q, fall, din;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= '1;
            s2_q        <= '1;
            filt_q      <= '1;
            fclk_prev_q <= '1;
            for (int i = 0; i < L; i++) gcnt_q[i] <= '0;
        end else begin
            s1_q        <= {ps2_data, ps2_clk};
            s2_q        <= s1_q;
            fclk_prev_q <= filt_q[NUM_CH-1:0];
            for (int i = 0; i < L; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    gcnt_q[i] <= '0;
                end else if (gcnt_q[i] == GW'(GLITCH - 1)) begin
                    filt_q[i] <= s2_q[i];
                    gcnt_q[i] <= '0;
                end else begin
                    gcnt_q[i] <= gcnt_q[i] + GW'(1);
                end
            end
        end
    end

    assign fall = fclk_prev_q & ~filt_q[NUM_CH-1:0];
    assign din  = filt_q[L-1:NUM_CH];

    // Per-channel frame receivers; a finished frame parks {err, data} in a pending slot.
    logic [NUM_CH-1:0] pend, grant;
    logic [8:0]        ent [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_rx
        rx_state_e     st_q;
        logic [2:0]    bit_q;
        logic [7:0]    sh_q;
        logic          par_q;
        logic [TW-1:0] to_q;
        logic          pend_q;
        logic [8:0]    ent_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                st_q   <= IDLE;
                bit_q  <= '0;
                sh_q   <= '0;
                par_q  <= 1'b0;
                to_q   <= '0;
                pend_q <= 1'b0;
                ent_q  <= '0;
            end else begin
                if (grant[c]) pend_q <= 1'b0;
                if (fall[c]) begin
                    to_q <= '0;
                    case (st_q)
                        IDLE: if (!din[c]) begin
                            st_q  <= DATA;
                            bit_q <= '0;
                        end
                        DATA: begin
                            sh_q  <= {din[c], sh_q[7:1]};
                            bit_q <= bit_q + 3'd1;
                            if (bit_q == 3'd7) st_q <= PARITY;
                        end
                        PARITY: begin
                            par_q <= din[c];
                            st_q  <= STOP;
                        end
                        STOP: begin
                            // Odd parity expected: even total of ones, or a low stop bit, flags an error.
                            pend_q <= 1'b1;
                            ent_q  <= {~(^sh_q ^ par_q) | ~din[c], sh_q};
                            st_q   <= IDLE;
                        end
                    endcase
                end else if (st_q == IDLE) begin
                    to_q <= '0;
                end else if (to_q == TW'(TIMEOUT - 1)) begin
                    st_q <= IDLE;
                    to_q <= '0;
                end else begin
                    to_q <= to_q + TW'(1);
                end
            end
        end

        assign pend[c] = pend_q;
        assign ent[c]  = ent_q;
    end

    // Fixed priority merge: lowest pending channel wins this cycle.
    logic          push;
    logic [EW-1:0] push_ent;

    always_comb begin
        grant    = '0;
        push_ent = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                push_ent = {CHW'(i), ent[i]};
            end
        end
    end

    assign push = |pend;

    // Shared FIFO and bus read side.
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          cs_s1_q, cs_s2_q;
    logic [SW-1:0] cs_cnt_q;
    logic          empty_q, full_q, ovf_q, int_q, rd_err_q;
    logic [7:0]    rd_data_q;
    logic [CHW-1:0] rd_ch_q;
    logic          do_pop, do_push;

    // The pop fires on the single edge where the cs counter reaches CS_STABLE.
    assign do_pop  = cs_s2_q && cs_cnt_q == SW'(CS_STABLE - 1) && !empty_q;
    assign do_push = push && (!full_q || do_pop);
    assign cnt_d   = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= push_ent;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            int_q     <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_cnt_q  <= '0;
            rd_data_q <= '0;
            rd_ch_q   <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            cs_s1_q  <= cs;
            cs_s2_q  <= cs_s1_q;
            cs_cnt_q <= !cs_s2_q ? '0 : (cs_cnt_q == SW'(CS_STABLE)) ? cs_cnt_q : cs_cnt_q + SW'(1);
            cnt_q    <= cnt_d;
            empty_q  <= cnt_d == '0;
            full_q   <= cnt_d == (AW + 1)'(FIFO_DEPTH);
            ovf_q    <= (push && full_q && !do_pop) | (ovf_q & ~int_clear);
            int_q    <= do_push | (int_q & ~int_clear);
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop) begin
                rp_q <= rp_q + AW'(1);
                {rd_ch_q, rd_err_q, rd_data_q} <= mem_q[rp_q];
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_ch     = rd_ch_q;
    assign rd_err    = rd_err_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = ovf_q;
    assign interrupt = int_q;
endmodule

// File: tb/tb_ps2_multi_host_rx.sv
// tb_ps2_multi_host_rx: randomized scoreboard bench for the two-port PS/2 receiver
module tb_ps2_multi_host_rx;
    localparam int NUM_CH    = 2;
    localparam int DEPTH     = 8;
    localparam int TIMEOUT   = 2047;
    localparam int CS_STABLE = 2;

    logic       clk = 1'b0, reset = 1'b1, cs = 1'b0, int_clear = 1'b0;
    logic [1:0] ps2_clk = '1, ps2_data = '1;
    wire        vpwr, vgnd;
    logic [7:0] rd_data;
    logic       rd_ch, rd_err, empty, full, overflow, interrupt;

    assign vpwr = 1'b1;
    assign vgnd = 1'b0;

    ps2_multi_host_rx #(
        .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .GLITCH(4), .TIMEOUT(TIMEOUT), .CS_STABLE(CS_STABLE)
    ) dut (
        .clk(clk), .reset(reset), .VPWR(vpwr), .VGND(vgnd),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .cs(cs), .int_clear(int_clear),
        .rd_data(rd_data), .rd_ch(rd_ch), .rd_err(rd_err), .empty(empty), .full(full),
        .overflow(overflow), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_bad = 0;
    logic [9:0] exp_q[$];
    logic [9:0] last = '0;
    logic       m_int = 1'b0, m_ovf = 1'b0;
    bit         exp_pop;
    event       rd_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bits in send order: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~^d ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    function automatic logic [9:0] expect_of(input logic ch, input logic [10:0] f);
        int ones;
        ones = $countones(f[8:1]) + int'(f[9]);
        return {ch, (ones % 2 == 0) || (f[10] == 1'b0), f[8:1]};
    endfunction

    task automatic send(input logic [1:0] en, input logic [10:0] f0, input logic [10:0] f1,
                        input int nbits, input int h, input bit glitch);
        for (int b = 0; b < nbits; b++) begin
            @(negedge clk);
            if (en[0]) ps2_data[0] = f0[b];
            if (en[1]) ps2_data[1] = f1[b];
            repeat (h) @(negedge clk);
            ps2_clk = ps2_clk & ~en;
            repeat (h) @(negedge clk);
            ps2_clk = ps2_clk | en;
            if (glitch && b == 4) begin
                repeat (h) @(negedge clk);
                ps2_clk = ps2_clk & ~en;
                repeat (2) @(negedge clk);
                ps2_clk = ps2_clk | en;
            end
        end
        repeat (h) @(negedge clk);
        ps2_data = ps2_data | en;
        repeat (h + 4) @(negedge clk);
    endtask

    task automatic tx(input logic [1:0] en, input logic [10:0] f0, input logic [10:0] f1,
                      input int h, input bit glitch);
        send(en, f0, f1, 11, h, glitch);
        for (int c = 0; c < NUM_CH; c++) begin
            if (en[c]) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(expect_of(c[0], c == 0 ? f0 : f1));
                    m_int = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic rd(input int n);
        @(negedge clk);
        cs = 1'b1;
        repeat (n) @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        exp_pop = (n >= CS_STABLE);
        ->rd_ev;
        @(negedge clk);
    endtask

    task automatic clr();
        @(negedge clk);
        int_clear = 1'b1;
        @(negedge clk);
        int_clear = 1'b0;
        m_int = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".empty"}, empty, exp_q.size() == 0);
        chk({tag, ".full"}, full, exp_q.size() == DEPTH);
        chk({tag, ".overflow"}, overflow, m_ovf);
        chk({tag, ".interrupt"}, interrupt, m_int);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cs = 1'b0;
        ps2_clk = '1;
        ps2_data = '1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        last = '0;
        m_int = 1'b0;
        m_ovf = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: on every bus read, compare the DUT read registers with the scoreboard head.
    initial forever begin
        @(rd_ev);
        if (exp_pop && exp_q.size() > 0) last = exp_q.pop_front();
        chk("rd_data", rd_data, last[7:0]);
        chk("rd_ch", rd_ch, last[9]);
        chk("rd_err", rd_err, last[8]);
        chk("rd.empty", empty, exp_q.size() == 0);
        chk("rd.full", full, exp_q.size() == DEPTH);
    end

    initial begin
        do_reset();
        chk("reset.rd_data", rd_data, 0);
        chk("reset.rd_ch", rd_ch, 0);
        chk("reset.rd_err", rd_err, 0);
        chk_flags("reset");

        tx(2'b01, frame(8'h1C, 0, 0), '1, 10, 0);
        chk_flags("ch0_1c");
        rd(2);

        tx(2'b10, '1, frame(8'hF0, 1, 0), 10, 0);
        tx(2'b01, frame(8'h12, 0, 1), '1, 10, 0);
        chk_flags("errs");
        rd(2);
        rd(2);

        tx(2'b11, frame(8'hAA, 0, 0), frame(8'h55, 0, 0), 10, 0);
        chk_flags("simul");
        rd(2);
        rd(2);

        for (int i = 1; i <= 9; i++) tx(2'b01, frame(8'(i), 0, 0), '1, 9, 0);
        chk_flags("fill");
        for (int i = 0; i < 9; i++) rd(2);
        clr();
        chk_flags("clear");

        send(2'b01, frame(8'hC3, 0, 0), '1, 4, 10, 0);
        repeat (TIMEOUT + 10) @(negedge clk);
        tx(2'b01, frame(8'h29, 0, 0), '1, 10, 0);
        chk_flags("timeout");
        rd(2);

        tx(2'b01, frame(8'($urandom), 0, 0), '1, 10, 1);
        chk_flags("glitch");
        rd(2);

        tx(2'b10, '1, frame(8'($urandom), 0, 0), 10, 0);
        rd(1);
        rd(20);
        rd(20);

        for (int it = 0; it < 12; it++) begin
            logic [1:0] en;
            en = 2'($urandom_range(1, 3));
            tx(en, frame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0),
                   frame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0),
               $urandom_range(8, 14), 0);
            chk_flags("rand");
            repeat ($urandom_range(0, 2)) rd($urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0) clr();
        end

        while (exp_q.size() > 0) rd(2);
        for (int i = 0; i < 3; i++) tx(2'b01, frame(8'($urandom), 0, 0), '1, 9, 0);
        chk_flags("pre_reset");
        send(2'b10, '1, frame(8'h77, 0, 0), 5, 10, 0);
        do_reset();
        chk("midreset.rd_data", rd_data, 0);
        chk_flags("midreset");
        tx(2'b10, '1, frame(8'h5A, 0, 0), 10, 0);
        chk_flags("post_reset");
        rd(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_multi_host_rx.md
Name: ps2_multi_host_rx

Overview:
Parametrised successor to the single-port PS/2 keyboard front end. It accepts NUM_CH independent PS/2 device ports, such as a keyboard and a mouse. Each port gets line synchronisation, glitch filtering, an 11-bit frame receiver, a parity/stop check and a timeout abort. Accepted bytes are tagged with channel and error bit, merged into one shared FIFO, and read by the 68k bus through a glitch-filtered chip select, with a level interrupt and a sticky overflow flag.

Parameters:
NUM_CH, 2, number of PS/2 ports; CHW = max(1, clog2(NUM_CH)).
FIFO_DEPTH, 8, shared FIFO entries; power of 2, >= 2.
GLITCH, 4, consecutive clk cycles a synced PS/2 line must hold a new level before the filtered level changes.
TIMEOUT, 2047, clk cycles without a filtered falling clock edge before a partial frame is aborted.
CS_STABLE, 2, consecutive clk cycles cs must be sampled high to generate one pop; >= 1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
VPWR  inout  1  power rail, pass-through, no logic
VGND  inout  1  ground rail, pass-through, no logic
ps2_clk  input  NUM_CH  PS/2 clock lines, asynchronous, idle high
ps2_data  input  NUM_CH  PS/2 data lines, asynchronous, idle high
cs  input  1  bus chip select, asynchronous
int_clear  input  1  clears interrupt and overflow, level
rd_data  output  8  last popped byte
rd_ch  output  CHW  channel of last popped byte
rd_err  output  1  parity or stop error flag of last popped byte
empty  output  1  FIFO empty
full  output  1  FIFO full
overflow  output  1  sticky: a frame was dropped because the FIFO was full
interrupt  output  1  level: at least one push since last int_clear

Behaviour:
- Reset is synchronous and active-high.
  - Outputs: rd_data=0, rd_ch=0, rd_err=0, empty=1, full=0, overflow=0, interrupt=0.
  - Internal: all sync/filter flops=1, every receiver FSM in IDLE, FIFO pointers and count=0, CS counter=0.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Input conditioning:
  - Two-flop synchroniser on each line, cs included.
  - Per-line filter counter: the filtered level flips only after the synced level has differed from it for GLITCH consecutive cycles.
  - A falling clock edge is a 1-cycle pulse on the filtered-clock 1->0 transition.
  - Data is sampled from the filtered data line in the same cycle as that pulse.
- Receiver FSM, one per channel, states IDLE -> DATA -> PARITY -> STOP -> IDLE. All transitions occur only on falling edges.
  - IDLE: data=0 goes to DATA with bit count 0; data=1 is ignored.
  - DATA: shift in LSB first; after the 8th bit go to PARITY.
  - PARITY: latch the parity bit.
  - STOP: on the stop bit, raise a 1-cycle done with err = (popcount(data)+parity is even) OR (stop bit == 0), then go to IDLE.
  - Timeout counter clears on every falling edge and counts only outside IDLE. On reaching TIMEOUT it returns the FSM to IDLE and nothing is pushed.
- Merge:
  - Each channel holds {data, err} in a pending register from done until its push is granted.
  - Fixed priority: lowest channel index pushes first, one push per cycle.
  - Pending waits at most NUM_CH-1 cycles, which is far shorter than one frame.
- FIFO:
  - Entry is {ch, err, data}. Count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - Push while full with no pop: entry dropped, overflow set to 1.
  - Push and pop in the same cycle while full: both take effect, count unchanged, no overflow.
  - empty/full are registered and reflect the count after each edge.
- Read:
  - cs_cnt increments on each edge with synced cs=1, saturating at CS_STABLE; it clears when cs=0.
  - A pop occurs on the edge where cs_cnt goes CS_STABLE-1 -> CS_STABLE.
  - On that edge rd_data/rd_ch/rd_err load the FIFO head and the head advances.
  - Exactly one pop per cs high period.
  - Pop while empty: no effect; rd_* hold their values and no underflow occurs.
- Interrupt:
  - Set by any accepted push.
  - Cleared by int_clear, which also clears overflow.
  - A push in the same cycle as int_clear wins: interrupt=1.

Test Plan:
- Ch0 frame 0x1C, parity 0, stop 1 -> empty 1->0, interrupt=1; then cs high 2 cycles -> rd_data=0x1C, rd_ch=0, rd_err=0, empty=1.
- Ch1 frame 0xF0 with parity 0 (bad) -> entry rd_data=0xF0, rd_ch=1, rd_err=1; stop bit 0 on a ch0 0x12 frame -> rd_err=1.
- Both channels complete frames (ch0 0xAA, ch1 0x55) on the same cycle -> two pops return (0xAA, ch 0) then (0x55, ch 1).
- Nine valid ch0 frames 0x01..0x09, no reads -> full=1, overflow=1, 0x09 dropped; 8 pops return 0x01..0x08; int_clear -> overflow=0, interrupt=0.
- Timeout and glitches:
  - Start bit + 3 data bits, then no clock for TIMEOUT+10 cycles, then a valid 0x29 frame -> FIFO holds only 0x29.
  - A 2-cycle low pulse on ps2_clk mid-frame -> ignored, frame received intact.
- Chip select and reset:
  - cs high 1 cycle -> no pop.
  - cs held 20 cycles -> exactly one pop.
  - reset asserted mid-frame with 3 entries queued -> empty=1, interrupt=0, rd_data=0; the next frame is received normally.
